// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-EX bundle: decode-side operand/control inputs, registered EX-side copies,
// hazard_stall back to decode/PC and the load-use bubble counter.
interface id_ex_pipe_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int JUMP_W     = 11,
    parameter int ALUOP_W    = 2,
    parameter int CNT_W      = 16
);
    logic                  flush, stall, valid_in, uses_rt_in;
    logic [REG_ADDR_W-1:0] rs_addr_in, rt_addr_in, reg_dest_r_type_in, reg_dest_l_type_in;
    logic [DATA_W-1:0]     data_a_in, data_b_in, sign_extend_in;
    logic [JUMP_W-1:0]     jump_dest_in;
    logic                  RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in;
    logic [ALUOP_W-1:0]    ALUOp_in;

    logic [REG_ADDR_W-1:0] rs_addr_out, rt_addr_out, reg_dest_r_type_out, reg_dest_l_type_out;
    logic [DATA_W-1:0]     data_a_out, data_b_out, sign_extend_out;
    logic [JUMP_W-1:0]     jump_dest_out;
    logic                  RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out;
    logic [ALUOP_W-1:0]    ALUOp_out;
    logic                  valid_out, hazard_stall;
    logic [CNT_W-1:0]      bubble_count;

    modport master (
        output flush, stall, valid_in, uses_rt_in, rs_addr_in, rt_addr_in,
               reg_dest_r_type_in, reg_dest_l_type_in, data_a_in, data_b_in, sign_extend_in,
               jump_dest_in, RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in,
               MemWrite_in, Branch_in, ALUOp_in,
        input  rs_addr_out, rt_addr_out, reg_dest_r_type_out, reg_dest_l_type_out,
               data_a_out, data_b_out, sign_extend_out, jump_dest_out, RegDst_out, ALUSrc_out,
               MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out, ALUOp_out,
               valid_out, hazard_stall, bubble_count
    );

    modport slave (
        input  flush, stall, valid_in, uses_rt_in, rs_addr_in, rt_addr_in,
               reg_dest_r_type_in, reg_dest_l_type_in, data_a_in, data_b_in, sign_extend_in,
               jump_dest_in, RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in,
               MemWrite_in, Branch_in, ALUOp_in,
        output rs_addr_out, rt_addr_out, reg_dest_r_type_out, reg_dest_l_type_out,
               data_a_out, data_b_out, sign_extend_out, jump_dest_out, RegDst_out, ALUSrc_out,
               MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out, ALUOp_out,
               valid_out, hazard_stall, bubble_count
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, flush/stall and load-use bubble insertion.
// Latency: 1 cycle input to outputs.
// Backpressure: stall holds everything; hazard_stall asks decode/PC to hold for one cycle.
module id_ex_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int JUMP_W     = 11,
    parameter int ALUOP_W    = 2,
    parameter int CNT_W      = 16
) (
    input logic             clock,
    input logic             reset,
    id_ex_pipe_reg_if.slave bus
);
    typedef struct packed {
        logic [DATA_W-1:0]     data_a;
        logic [DATA_W-1:0]     data_b;
        logic [DATA_W-1:0]     sign_extend;
        logic [JUMP_W-1:0]     jump_dest;
        logic [REG_ADDR_W-1:0] rs_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [REG_ADDR_W-1:0] reg_dest_r_type;
        logic [REG_ADDR_W-1:0] reg_dest_l_type;
    } dat_t;

    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic               mem_to_reg;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    dat_t             dat_in, dat_q;
    ctrl_t            ctrl_in, ctrl_q;
    logic             valid_q;
    logic [CNT_W-1:0] bubble_q;
    logic             load_use;

    assign dat_in  = {bus.data_a_in, bus.data_b_in, bus.sign_extend_in, bus.jump_dest_in,
                      bus.rs_addr_in, bus.rt_addr_in, bus.reg_dest_r_type_in, bus.reg_dest_l_type_in};
    assign ctrl_in = {bus.RegDst_in, bus.ALUSrc_in, bus.MemToReg_in, bus.RegWrite_in,
                      bus.MemRead_in, bus.MemWrite_in, bus.Branch_in, bus.ALUOp_in};

    assign {bus.data_a_out, bus.data_b_out, bus.sign_extend_out, bus.jump_dest_out,
            bus.rs_addr_out, bus.rt_addr_out, bus.reg_dest_r_type_out, bus.reg_dest_l_type_out} = dat_q;
    assign {bus.RegDst_out, bus.ALUSrc_out, bus.MemToReg_out, bus.RegWrite_out,
            bus.MemRead_out, bus.MemWrite_out, bus.Branch_out, bus.ALUOp_out} = ctrl_q;
    assign bus.valid_out    = valid_q;
    assign bus.bubble_count = bubble_q;

    // A load in EX whose destination is read by the decode instruction; $0 is never a real dependency.
    assign load_use = valid_q & ctrl_q.mem_read & (dat_q.reg_dest_l_type != '0) & bus.valid_in &
                      ((dat_q.reg_dest_l_type == bus.rs_addr_in) |
                       (bus.uses_rt_in & (dat_q.reg_dest_l_type == bus.rt_addr_in)));

    assign bus.hazard_stall = load_use & ~bus.flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dat_q    <= '0;
            ctrl_q   <= '0;
            valid_q  <= 1'b0;
            bubble_q <= '0;
        end else if (bus.flush || !bus.stall) begin
            // Payload always loads on a bubble; only controls and valid are squashed.
            dat_q <= dat_in;
            if (bus.flush || load_use) begin
                ctrl_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                ctrl_q  <= ctrl_in;
                valid_q <= bus.valid_in;
            end
            if (!bus.flush && load_use && (bubble_q != '1)) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios plus randomized traffic against an instruction-level model.
module tb_id_ex_pipe_reg;
    typedef struct packed {
        logic flush, stall, valid_in, uses_rt;
        logic [4:0] rs, rt;
        logic [31:0] data_a, data_b, imm;
        logic [10:0] jd;
        logic [4:0] rd_r, rd_l;
        logic reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
        logic [1:0] alu_op;
    } stim_t;

    typedef struct packed {
        logic valid;
        logic [31:0] data_a, data_b, imm;
        logic [10:0] jd;
        logic [4:0] rs, rt, rd_r, rd_l;
        logic reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
        logic [1:0] alu_op;
    } ex_t;

    logic  clock = 1'b0;
    logic  reset = 1'b1;
    logic  chk_en = 1'b0;
    stim_t s = '0;
    ex_t   m = '0;
    int    cnt_l = 0, cnt_s = 0;
    int    vectors = 0, miscompares = 0;

    always #5 clock = ~clock;

    id_ex_pipe_reg_if #(.CNT_W(16)) bus_a ();
    id_ex_pipe_reg_if #(.CNT_W(2))  bus_s ();

    id_ex_pipe_reg #(.CNT_W(16)) dut   (.clock(clock), .reset(reset), .bus(bus_a));
    id_ex_pipe_reg #(.CNT_W(2))  dut_s (.clock(clock), .reset(reset), .bus(bus_s));

    assign {bus_a.flush, bus_a.stall, bus_a.valid_in, bus_a.uses_rt_in, bus_a.rs_addr_in, bus_a.rt_addr_in,
            bus_a.data_a_in, bus_a.data_b_in, bus_a.sign_extend_in, bus_a.jump_dest_in,
            bus_a.reg_dest_r_type_in, bus_a.reg_dest_l_type_in, bus_a.RegDst_in, bus_a.ALUSrc_in,
            bus_a.MemToReg_in, bus_a.RegWrite_in, bus_a.MemRead_in, bus_a.MemWrite_in,
            bus_a.Branch_in, bus_a.ALUOp_in} = s;
    assign {bus_s.flush, bus_s.stall, bus_s.valid_in, bus_s.uses_rt_in, bus_s.rs_addr_in, bus_s.rt_addr_in,
            bus_s.data_a_in, bus_s.data_b_in, bus_s.sign_extend_in, bus_s.jump_dest_in,
            bus_s.reg_dest_r_type_in, bus_s.reg_dest_l_type_in, bus_s.RegDst_in, bus_s.ALUSrc_in,
            bus_s.MemToReg_in, bus_s.RegWrite_in, bus_s.MemRead_in, bus_s.MemWrite_in,
            bus_s.Branch_in, bus_s.ALUOp_in} = s;

    ex_t dut_vec_a, dut_vec_s;
    assign dut_vec_a = {bus_a.valid_out, bus_a.data_a_out, bus_a.data_b_out, bus_a.sign_extend_out,
                        bus_a.jump_dest_out, bus_a.rs_addr_out, bus_a.rt_addr_out, bus_a.reg_dest_r_type_out,
                        bus_a.reg_dest_l_type_out, bus_a.RegDst_out, bus_a.ALUSrc_out, bus_a.MemToReg_out,
                        bus_a.RegWrite_out, bus_a.MemRead_out, bus_a.MemWrite_out, bus_a.Branch_out,
                        bus_a.ALUOp_out};
    assign dut_vec_s = {bus_s.valid_out, bus_s.data_a_out, bus_s.data_b_out, bus_s.sign_extend_out,
                        bus_s.jump_dest_out, bus_s.rs_addr_out, bus_s.rt_addr_out, bus_s.reg_dest_r_type_out,
                        bus_s.reg_dest_l_type_out, bus_s.RegDst_out, bus_s.ALUSrc_out, bus_s.MemToReg_out,
                        bus_s.RegWrite_out, bus_s.MemRead_out, bus_s.MemWrite_out, bus_s.Branch_out,
                        bus_s.ALUOp_out};

    // The instruction the EX stage would hold: payload copied, controls squashed when it is a bubble.
    function automatic ex_t capture(stim_t x, bit bubble);
        ex_t e;
        e = {x.valid_in, x.data_a, x.data_b, x.imm, x.jd, x.rs, x.rt, x.rd_r, x.rd_l, x.reg_dst,
             x.alu_src, x.mem_to_reg, x.reg_write, x.mem_read, x.mem_write, x.branch, x.alu_op};
        if (bubble) begin
            e.valid = 0; e.reg_dst = 0; e.alu_src = 0; e.mem_to_reg = 0; e.reg_write = 0;
            e.mem_read = 0; e.mem_write = 0; e.branch = 0; e.alu_op = 2'b00;
        end
        return e;
    endfunction

    function automatic bit model_load_use(ex_t e, stim_t x);
        return e.valid && e.mem_read && (e.rd_l != 0) && x.valid_in &&
               ((e.rd_l == x.rs) || (x.uses_rt && e.rd_l == x.rt));
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m = '0; cnt_l = 0; cnt_s = 0;
        end else if (s.flush) begin
            m = capture(s, 1'b1);
        end else if (!s.stall) begin
            if (model_load_use(m, s)) begin
                m = capture(s, 1'b1);
                cnt_l = (cnt_l + 1 > 65535) ? 65535 : cnt_l + 1;
                cnt_s = (cnt_s + 1 > 3) ? 3 : cnt_s + 1;
            end else begin
                m = capture(s, 1'b0);
            end
        end
    end

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            bit hz;
            hz = model_load_use(m, s) && !s.flush;
            vectors += 6;
            if (dut_vec_a !== m) begin
                miscompares++; $display("FAIL regs got=%h exp=%h", dut_vec_a, m);
            end
            if (dut_vec_s !== m) begin
                miscompares++; $display("FAIL regs_small got=%h exp=%h", dut_vec_s, m);
            end
            if (bus_a.hazard_stall !== hz) begin
                miscompares++; $display("FAIL hazard got=%b exp=%b", bus_a.hazard_stall, hz);
            end
            if (bus_s.hazard_stall !== hz) begin
                miscompares++; $display("FAIL hazard_small got=%b exp=%b", bus_s.hazard_stall, hz);
            end
            if (bus_a.bubble_count !== 16'(cnt_l)) begin
                miscompares++; $display("FAIL count got=%0d exp=%0d", bus_a.bubble_count, cnt_l);
            end
            if (bus_s.bubble_count !== 2'(cnt_s)) begin
                miscompares++; $display("FAIL count_small got=%0d exp=%0d", bus_s.bubble_count, cnt_s);
            end
        end
    end

    function automatic stim_t lw(logic [4:0] dest, logic [4:0] rs);
        stim_t x = '0;
        x.valid_in = 1; x.mem_read = 1; x.rd_l = dest; x.rs = rs; x.reg_write = 1;
        return x;
    endfunction

    task automatic edge_step();
        @(posedge clock); #1;
    endtask

    initial begin
        int sat_exp [5] = '{1, 2, 3, 3, 3};
        edge_step(); edge_step();
        reset = 0;
        s = '1; s.flush = 0; s.stall = 0;
        chk_en = 1;
        edge_step();
        chk("pre_reset_valid", bus_a.valid_out, 1);
        s.flush = 1; s.stall = 1;
        #2 reset = 1;
        #1;
        chk("reset_regs", |dut_vec_a, 0);
        chk("reset_count", bus_a.bubble_count, 0);
        chk("reset_hazard", bus_a.hazard_stall, 0);
        #1 reset = 0;

        s = '0; s.data_a = 32'h12345678; s.alu_op = 2'b10; s.reg_write = 1; s.valid_in = 1;
        edge_step();
        chk("normal_data_a", bus_a.data_a_out, 64'h12345678);
        chk("normal_aluop", bus_a.ALUOp_out, 2);
        chk("normal_regwrite", bus_a.RegWrite_out, 1);
        chk("normal_valid", bus_a.valid_out, 1);

        s = lw(5'd8, 5'd0);
        edge_step();
        s = '0; s.valid_in = 1; s.rs = 8; s.reg_write = 1;
        #1 chk("lu_rs_hazard", bus_a.hazard_stall, 1);
        edge_step();
        chk("lu_bubble_valid", bus_a.valid_out, 0);
        chk("lu_bubble_memread", bus_a.MemRead_out, 0);
        chk("lu_count", bus_a.bubble_count, 1);
        chk("lu_represent_hazard", bus_a.hazard_stall, 0);
        edge_step();
        chk("lu_reload_valid", bus_a.valid_out, 1);
        chk("lu_reload_regwrite", bus_a.RegWrite_out, 1);

        s = lw(5'd8, 5'd0);
        edge_step();
        s = '0; s.valid_in = 1; s.rs = 3; s.rt = 8; s.uses_rt = 0;
        #1 chk("rt_unused_hazard", bus_a.hazard_stall, 0);
        s.uses_rt = 1;
        #1 chk("rt_used_hazard", bus_a.hazard_stall, 1);
        s.flush = 1;
        #1 chk("flush_hazard", bus_a.hazard_stall, 0);
        edge_step();
        chk("flush_valid", bus_a.valid_out, 0);
        chk("flush_count", bus_a.bubble_count, 1);

        s = lw(5'd0, 5'd0);
        edge_step();
        s = '0; s.valid_in = 1; s.rs = 0;
        #1 chk("r0_hazard", bus_a.hazard_stall, 0);

        s = '0; s.valid_in = 1; s.data_a = 32'hAAAA5555; s.reg_write = 1;
        edge_step();
        for (int i = 0; i < 3; i++) begin
            s = stim_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
            s.stall = 1; s.flush = 0;
            edge_step();
            chk("stall_data_a", bus_a.data_a_out, 64'hAAAA5555);
            chk("stall_valid", bus_a.valid_out, 1);
            chk("stall_count", bus_a.bubble_count, 1);
        end

        s = '0; s.valid_in = 1; s.reg_write = 1; s.flush = 1; s.stall = 1;
        edge_step();
        chk("flush_stall_valid", bus_a.valid_out, 0);
        chk("flush_stall_regwrite", bus_a.RegWrite_out, 0);

        #1 reset = 1;
        #1 reset = 0;
        s = lw(5'd8, 5'd8);
        for (int i = 0; i < 5; i++) begin
            edge_step();
            edge_step();
            chk("sat_small", bus_s.bubble_count, 64'(sat_exp[i]));
            chk("sat_wide", bus_a.bubble_count, 64'(i + 1));
        end

        for (int i = 0; i < 3000; i++) begin
            edge_step();
            if (reset) reset = 0;
            else if ($urandom_range(99) == 0) reset = 1;
            s = stim_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
            s.flush    = ($urandom_range(9) == 0);
            s.stall    = ($urandom_range(6) == 0);
            s.valid_in = ($urandom_range(7) != 0);
            s.rs       = 5'($urandom_range(3));
            s.rt       = 5'($urandom_range(3));
            s.rd_l     = 5'($urandom_range(3));
        end

        edge_step();
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
